// File: rtl/char_sprite_sched.sv
// Shares one character-sprite ROM port between the two player painters, one pixel at a time.
// Fetches the player-1 then player-2 texel in fixed slots and composes them over the background.
module char_sprite_sched #(
  parameter int unsigned SPR_W     = 64,
  parameter int unsigned SPR_H     = 48,
  parameter logic [7:0]  TRANSP    = 8'b111_000_11,
  parameter bit          P1_ON_TOP = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_en,
  input  logic        frame_start,
  input  logic [9:0]  hc,
  input  logic [9:0]  vc,
  input  logic [7:0]  bg_rgb,
  input  logic [9:0]  p1_x,
  input  logic [9:0]  p1_y,
  input  logic [9:0]  p2_x,
  input  logic [9:0]  p2_y,
  input  logic        p1_alive,
  input  logic        p2_alive,
  output logic        rom_en,
  output logic [12:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic [2:0]  red,
  output logic [2:0]  green,
  output logic [1:0]  blue,
  output logic        pix_valid,
  output logic        overrun,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, F1 = 2'd1, F2 = 2'd2, CMP = 2'd3} state_t;

  state_t      state_q, state_d;
  logic [9:0]  s1_x_q, s1_y_q, s2_x_q, s2_y_q;
  logic        s1_alive_q, s2_alive_q;
  logic        hit1_q, hit2_q;
  logic [11:0] addr2_q;
  logic [7:0]  bg_q, c1_q;
  logic        rom_en_q, rom_en_d;
  logic [12:0] rom_addr_q, rom_addr_d;
  logic [7:0]  rgb_q, rgb_d;
  logic        pix_valid_q, pix_valid_d;
  logic        overrun_q;
  logic        load_c1;
  logic        hit1_c, hit2_c;
  logic [11:0] addr1_c, addr2_c;
  logic        op1, op2;

  // 11-bit compare so a sprite near the right/bottom edge never wraps back to column/row 0.
  function automatic logic hit_f(input logic alive, input logic [9:0] x, input logic [9:0] y,
                                 input logic [9:0] h, input logic [9:0] v);
    logic [10:0] hx, vy, px, py;
    hx = {1'b0, h};
    vy = {1'b0, v};
    px = {1'b0, x};
    py = {1'b0, y};
    return alive && (hx >= px) && (hx < px + 11'(SPR_W)) && (vy >= py) && (vy < py + 11'(SPR_H));
  endfunction

  function automatic logic [11:0] addr_f(input logic [9:0] x, input logic [9:0] y,
                                         input logic [9:0] h, input logic [9:0] v);
    logic [11:0] col, row;
    col = {2'b00, h - x};
    row = {2'b00, v - y};
    return row * 12'(SPR_W) + col;
  endfunction

  assign hit1_c  = hit_f(s1_alive_q, s1_x_q, s1_y_q, hc, vc);
  assign hit2_c  = hit_f(s2_alive_q, s2_x_q, s2_y_q, hc, vc);
  assign addr1_c = addr_f(s1_x_q, s1_y_q, hc, vc);
  assign addr2_c = addr_f(s2_x_q, s2_y_q, hc, vc);

  assign op1 = hit1_q && (c1_q != TRANSP);
  assign op2 = hit2_q && (rom_data != TRANSP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Any pix_en restarts the sequence at F1, which also covers the abort case.
  always_comb begin
    state_d = state_q;
    if (pix_en) begin
      state_d = F1;
    end else begin
      case (state_q)
        F1:      state_d = F2;
        F2:      state_d = CMP;
        CMP:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    rom_en_d    = 1'b0;
    rom_addr_d  = rom_addr_q;
    pix_valid_d = 1'b0;
    rgb_d       = rgb_q;
    load_c1     = 1'b0;
    if (pix_en) begin
      rom_en_d = hit1_c;
      if (hit1_c) rom_addr_d = {1'b0, addr1_c};
    end else begin
      case (state_q)
        F1: begin
          rom_en_d = hit2_q;
          if (hit2_q) rom_addr_d = {1'b1, addr2_q};
        end
        F2: load_c1 = 1'b1;
        CMP: begin
          pix_valid_d = 1'b1;
          if (P1_ON_TOP) rgb_d = op1 ? c1_q : (op2 ? rom_data : bg_q);
          else           rgb_d = op2 ? rom_data : (op1 ? c1_q : bg_q);
        end
        default: ;
      endcase
    end
  end

  // Shadows are written at the edge, so a pixel captured together with frame_start sees the old frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_x_q      <= '0;
      s1_y_q      <= '0;
      s2_x_q      <= '0;
      s2_y_q      <= '0;
      s1_alive_q  <= 1'b0;
      s2_alive_q  <= 1'b0;
      hit1_q      <= 1'b0;
      hit2_q      <= 1'b0;
      addr2_q     <= '0;
      bg_q        <= '0;
      c1_q        <= '0;
      rom_en_q    <= 1'b0;
      rom_addr_q  <= '0;
      rgb_q       <= '0;
      pix_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (frame_start) begin
        s1_x_q     <= p1_x;
        s1_y_q     <= p1_y;
        s2_x_q     <= p2_x;
        s2_y_q     <= p2_y;
        s1_alive_q <= p1_alive;
        s2_alive_q <= p2_alive;
      end
      if (pix_en) begin
        hit1_q  <= hit1_c;
        hit2_q  <= hit2_c;
        addr2_q <= addr2_c;
        bg_q    <= bg_rgb;
      end
      if (load_c1) c1_q <= rom_data;
      if (pix_en && (state_q != IDLE)) overrun_q <= 1'b1;
      rom_en_q    <= rom_en_d;
      rom_addr_q  <= rom_addr_d;
      rgb_q       <= rgb_d;
      pix_valid_q <= pix_valid_d;
    end
  end

  assign rom_en    = rom_en_q;
  assign rom_addr  = rom_addr_q;
  assign red       = rgb_q[7:5];
  assign green     = rgb_q[4:2];
  assign blue      = rgb_q[1:0];
  assign pix_valid = pix_valid_q;
  assign overrun   = overrun_q;
  assign dbg_state = state_q;

endmodule
